// File: rtl/action_executor.sv
// action_executor: fetches a match-action entry over a byte-wide memory port
// and applies it (NOP, SET_FIELD into a parsed header, or DROP).
// Optional build macro: EXEC_MISS_DROP_EN -- a table miss reports drop_o=1.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FREE     | idle, waiting for start_i
// LOAD_ACT | reading entry bytes +0..+3 (opcode, hdr_id, offset, length)
// DECODE   | classify the entry: drop, nop or valid set-field
// LOAD_VAL | reading L value bytes (+4..+3+L) into the value buffer
// WRITE    | writing L value bytes to parsed_hdrs[hdr_id] + offset
// DONE     | ready_o/drop_o held until start_i drops
module action_executor (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] val_addr_i,
    input  logic [63:0] parsed_hdrs_i,
    output logic        mem_ce_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_width_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    output logic        ready_o,
    output logic        drop_o
);

`ifdef EXEC_MISS_DROP_EN
    localparam logic MISS_DROP = 1'b1;
`else
    localparam logic MISS_DROP = 1'b0;
`endif

    typedef enum logic [2:0] {
        FREE     = 3'd0,
        LOAD_ACT = 3'd1,
        DECODE   = 3'd2,
        LOAD_VAL = 3'd3,
        WRITE    = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [7:0]  op_q, op_d;
    logic [7:0]  hdr_q, hdr_d;
    logic [7:0]  off_q, off_d;
    logic [7:0]  len_q, len_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  val_q [0:7];
    logic [7:0]  val_d [0:7];
    logic        drop_q, drop_d;

    logic [31:0] hdr_base;
    logic        last_byte;
    logic        set_valid;
    logic [7:0]  rd_byte;
    logic        unused_data_hi;

    // Only the low byte of the read bus carries data.
    assign rd_byte        = mem_data_i[7:0];
    assign unused_data_hi = ^mem_data_i[31:8];
    assign mem_width_o    = 4'd1;

    // Shared decode helpers for the sequencing and the address mux.
    always_comb begin
        hdr_base  = hdr_q[0] ? parsed_hdrs_i[31:0] : parsed_hdrs_i[63:32];
        last_byte = (({4'd0, cnt_q}) + 8'd1) == len_q;
        set_valid = (op_q == 8'd1) && (len_q != 8'd0) && (len_q <= 8'd8) &&
                    (hdr_q <= 8'd1);
    end

    // State and datapath registers; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FREE;
            base_q  <= '0;
            op_q    <= '0;
            hdr_q   <= '0;
            off_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            val_q   <= '{default: 8'h00};
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            op_q    <= op_d;
            hdr_q   <= hdr_d;
            off_q   <= off_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state logic and byte capture.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        op_d    = op_q;
        hdr_d   = hdr_q;
        off_d   = off_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        drop_d  = drop_q;
        case (state_q)
            FREE: begin
                if (start_i) begin
                    if (val_addr_i == 32'd0) begin
                        drop_d  = MISS_DROP;
                        state_d = DONE;
                    end else begin
                        base_d  = val_addr_i;
                        cnt_d   = 4'd0;
                        state_d = LOAD_ACT;
                    end
                end
            end
            LOAD_ACT: begin
                case (cnt_q[1:0])
                    2'd0:    op_d  = rd_byte;
                    2'd1:    hdr_d = rd_byte;
                    2'd2:    off_d = rd_byte;
                    default: len_d = rd_byte;
                endcase
                if (cnt_q == 4'd3) begin
                    cnt_d   = 4'd0;
                    state_d = DECODE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DECODE: begin
                cnt_d = 4'd0;
                if (op_q == 8'd2) begin
                    drop_d  = 1'b1;
                    state_d = DONE;
                end else if (set_valid) begin
                    state_d = LOAD_VAL;
                end else begin
                    drop_d  = 1'b0;
                    state_d = DONE;
                end
            end
            LOAD_VAL: begin
                val_d[cnt_q[2:0]] = rd_byte;
                if (last_byte) begin
                    cnt_d   = 4'd0;
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WRITE: begin
                if (last_byte) begin
                    drop_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (!start_i) state_d = FREE;
            end
            default: state_d = FREE;
        endcase
    end

    // Memory port and handshake outputs decoded from the current state.
    always_comb begin
        mem_ce_o   = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = 32'd0;
        mem_data_o = 32'd0;
        ready_o    = 1'b0;
        drop_o     = 1'b0;
        case (state_q)
            LOAD_ACT: begin
                mem_ce_o   = 1'b1;
                mem_addr_o = base_q + {28'd0, cnt_q};
            end
            LOAD_VAL: begin
                mem_ce_o   = 1'b1;
                mem_addr_o = base_q + 32'd4 + {28'd0, cnt_q};
            end
            WRITE: begin
                mem_ce_o   = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = hdr_base + {24'd0, off_q} + {28'd0, cnt_q};
                mem_data_o = {24'd0, val_q[cnt_q[2:0]]};
            end
            DONE: begin
                ready_o = 1'b1;
                drop_o  = drop_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_action_executor.sv
// Testbench for action_executor: directed vector table, reset/handshake
// sequences and randomized entries checked against a behavioural model.
module tb_action_executor;

`ifdef EXEC_MISS_DROP_EN
    localparam bit MISS_DROP = 1'b1;
`else
    localparam bit MISS_DROP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] val_addr_i = '0;
    logic [63:0] parsed_hdrs_i = '0;
    logic        mem_ce_o, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_width_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        ready_o, drop_o;

    action_executor dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .val_addr_i   (val_addr_i),
        .parsed_hdrs_i(parsed_hdrs_i),
        .mem_ce_o     (mem_ce_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_width_o  (mem_width_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .ready_o      (ready_o),
        .drop_o       (drop_o)
    );

    always #5 clk = ~clk;

    // 4 KiB byte memory aliased on the low 12 address bits; upper read bits
    // carry garbage so only the low byte may be used.
    logic [7:0] mem [0:4095];
    assign mem_data_i = {24'hC3A55A, mem[mem_addr_o[11:0]]};

    logic [31:0] wa [$];
    logic [7:0]  wd [$];
    int rd_cnt = 0;
    int side_bad = 0;

    always @(posedge clk) begin
        if (mem_ce_o && mem_we_o) begin
            wa.push_back(mem_addr_o);
            wd.push_back(mem_data_o[7:0]);
        end
        if (mem_ce_o && !mem_we_o) rd_cnt <= rd_cnt + 1;
        if (mem_width_o != 4'd1 || mem_data_o[31:8] != 24'd0 || (mem_we_o && !mem_ce_o))
            side_bad <= side_bad + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef logic [0:11][7:0] ent_t;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] hdrs;
        ent_t        ent;
        int          lat;
        bit          drop;
        int          nwr;
        logic [31:0] wbase;
        int          nrd;
    } vec_t;

    task automatic load_ent(input logic [31:0] a, input ent_t e);
        logic [11:0] idx;
        for (int k = 0; k < 12; k++) begin
            idx = a[11:0] + 12'(k);
            mem[idx] = e[k];
        end
    endtask

    // Behavioural reference: outcome of one request from the entry rules.
    task automatic model(input logic [31:0] a, input logic [63:0] h, output int lat,
                         output bit drp, output int nwr, output logic [31:0] wb,
                         output int nrd);
        logic [11:0] i0;
        logic [7:0]  op, hid, off, len;
        lat = 6; drp = 1'b0; nwr = 0; wb = 32'd0; nrd = 4;
        if (a == 32'd0) begin
            lat = 1; drp = MISS_DROP; nrd = 0;
        end else begin
            i0  = a[11:0];
            op  = mem[i0];
            hid = mem[i0 + 12'd1];
            off = mem[i0 + 12'd2];
            len = mem[i0 + 12'd3];
            if (op == 8'd2) begin
                drp = 1'b1;
            end else if (op == 8'd1 && len >= 1 && len <= 8 && hid <= 1) begin
                wb  = (hid == 8'd1 ? h[31:0] : h[63:32]) + 32'(off);
                nwr = int'(len);
                nrd = 4 + nwr;
                lat = 6 + 2 * nwr;
            end
        end
    endtask

    // One request/handshake; latency counted in cycles after the start cycle.
    task automatic run_txn(input logic [31:0] a, input logic [63:0] h, input int hold,
                           output int lat, output bit drp, output int nrd, output int w0);
        int r0, r1, wn;
        w0 = wa.size();
        r0 = rd_cnt;
        @(negedge clk);
        start_i = 1'b1; val_addr_i = a; parsed_hdrs_i = h;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (ready_o) break;
            if (lat >= 100) begin lat = 999; break; end
        end
        drp = drop_o;
        r1 = rd_cnt; wn = wa.size();
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            check("hold_ready", {63'd0, ready_o}, 64'd1);
        end
        if (hold > 0) begin
            check("hold_no_reads", 64'(rd_cnt), 64'(r1));
            check("hold_no_writes", 64'(wa.size()), 64'(wn));
        end
        nrd = r1 - r0;
        start_i = 1'b0;
        @(negedge clk);
        check("ready_fall", {63'd0, ready_o}, 64'd0);
    endtask

    task automatic check_writes(input string nm, input int w0, input int nwr,
                                input logic [31:0] wb, input ent_t e);
        check({nm, "_nwr"}, 64'(wa.size() - w0), 64'(nwr));
        for (int k = 0; k < nwr && (w0 + k) < wa.size(); k++) begin
            check({nm, "_waddr"}, 64'(wa[w0 + k]), 64'(wb + 32'(k)));
            check({nm, "_wdata"}, 64'(wd[w0 + k]), 64'(e[4 + k]));
        end
    endtask

    vec_t vt [11];

    initial begin
        int lat, nrd, w0, elat, enwr, enrd;
        bit drp, edrp;
        logic [31:0] ewb, a, h0, h1;
        ent_t e;

        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

        vt[0]  = '{32'd0,        {32'h200, 32'h40},       '0,                                                   1,  MISS_DROP, 0, 32'h0,   0};
        vt[1]  = '{32'd128,      {32'h200, 32'h40},       {8'h01,8'h01,8'h10,8'h04,8'hDE,8'hAD,8'hBE,8'hEF,32'h0}, 14, 1'b0, 4, 32'h50,  8};
        vt[2]  = '{32'd256,      {32'h200, 32'h40},       {8'h02,8'h01,8'h10,8'h04,64'hFFFF_FFFF_FFFF_FFFF},     6,  1'b1, 0, 32'h0,   4};
        vt[3]  = '{32'h180,      {32'h200, 32'h40},       {8'h01,8'h00,8'h00,8'h09,64'h1122_3344_5566_7788},     6,  1'b0, 0, 32'h0,   4};
        vt[4]  = '{32'h1C0,      {32'h200, 32'h40},       {8'h01,8'h02,8'h00,8'h02,64'h1122_3344_5566_7788},     6,  1'b0, 0, 32'h0,   4};
        vt[5]  = '{32'h200,      {32'h200, 32'h40},       {8'h00,8'h00,8'h04,8'h04,64'h1122_3344_5566_7788},     6,  1'b0, 0, 32'h0,   4};
        vt[6]  = '{32'h240,      {32'h200, 32'h40},       {8'h07,8'h01,8'h00,8'h01,64'h1122_3344_5566_7788},     6,  1'b0, 0, 32'h0,   4};
        vt[7]  = '{32'h280,      {32'h200, 32'h40},       {8'h01,8'h00,8'h00,8'h00,64'h1122_3344_5566_7788},     6,  1'b0, 0, 32'h0,   4};
        vt[8]  = '{32'h2C0,      {32'h300, 32'h900},      {8'h01,8'h00,8'h05,8'h08,64'h1122_3344_5566_7788},     22, 1'b0, 8, 32'h305, 12};
        vt[9]  = '{32'h340,      {32'h0, 32'hFFFF_FFF0},  {8'h01,8'h01,8'h20,8'h01,8'h5A,56'h0},                 8,  1'b0, 1, 32'h10,  5};
        vt[10] = '{32'hFFFF_F400,{32'h700, 32'h0},        {8'h01,8'h00,8'h02,8'h02,8'hC3,8'h3C,48'h0},           10, 1'b0, 2, 32'h702, 6};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_outputs", {32'd0, mem_addr_o | mem_data_o} | {58'd0, ready_o, drop_o, mem_ce_o, mem_we_o, 2'b00}, 64'd0);
        rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 11; i++) begin
            if (vt[i].addr != 32'd0) load_ent(vt[i].addr, vt[i].ent);
            run_txn(vt[i].addr, vt[i].hdrs, (i == 1) ? 5 : i % 3, lat, drp, nrd, w0);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
            check($sformatf("vec%0d_drop", i), {63'd0, drp}, {63'd0, vt[i].drop});
            check($sformatf("vec%0d_reads", i), 64'(nrd), 64'(vt[i].nrd));
            check_writes($sformatf("vec%0d", i), w0, vt[i].nwr, vt[i].wbase, vt[i].ent);
        end

        // Reset during LOAD_VAL of the set-field case, then a clean rerun.
        load_ent(vt[1].addr, vt[1].ent);
        @(negedge clk);
        start_i = 1'b1; val_addr_i = vt[1].addr; parsed_hdrs_i = vt[1].hdrs;
        repeat (8) @(negedge clk);
        rst = 1'b1; start_i = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", {32'd0, mem_addr_o | mem_data_o} | {58'd0, ready_o, drop_o, mem_ce_o, mem_we_o, 2'b00}, 64'd0);
        rst = 1'b0;
        run_txn(vt[1].addr, vt[1].hdrs, 0, lat, drp, nrd, w0);
        check("after_rst_latency", 64'(lat), 64'd14);
        check_writes("after_rst", w0, 4, 32'h50, vt[1].ent);

        // Reset during WRITE: two bytes land, no completion follows.
        w0 = wa.size();
        @(negedge clk);
        start_i = 1'b1;
        repeat (11) @(negedge clk);
        rst = 1'b1; start_i = 1'b0;
        @(negedge clk);
        check("rst_write_we", {63'd0, mem_we_o}, 64'd0);
        rst = 1'b0;
        check("rst_write_partial", 64'(wa.size() - w0), 64'd2);
        lat = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready_o) lat++;
        end
        check("rst_write_no_ready", 64'(lat), 64'd0);

        // Randomized entries against the reference model.
        for (int t = 0; t < 40; t++) begin
            int sel;
            sel = $urandom_range(0, 5);
            e = '0;
            e[0] = (sel == 0) ? 8'd0 : (sel <= 3) ? 8'd1 : (sel == 4) ? 8'd2 : 8'($urandom_range(3, 255));
            e[1] = 8'($urandom_range(0, 2));
            e[2] = 8'($urandom_range(0, 255));
            e[3] = 8'($urandom_range(0, 9));
            for (int k = 4; k < 12; k++) e[k] = 8'($urandom);
            a  = {20'($urandom), 12'h100 + 12'(16 * $urandom_range(0, 100))};
            if ($urandom_range(0, 7) == 0) a = 32'd0;
            h0 = {20'($urandom), 12'h800 + 12'($urandom_range(0, 12'h600))};
            h1 = {20'($urandom), 12'h800 + 12'($urandom_range(0, 12'h600))};
            if (a != 32'd0) load_ent(a, e);
            model(a, {h0, h1}, elat, edrp, enwr, ewb, enrd);
            run_txn(a, {h0, h1}, $urandom_range(0, 2), lat, drp, nrd, w0);
            check($sformatf("rnd%0d_latency", t), 64'(lat), 64'(elat));
            check($sformatf("rnd%0d_drop", t), {63'd0, drp}, {63'd0, edrp});
            check($sformatf("rnd%0d_reads", t), 64'(nrd), 64'(enrd));
            check_writes($sformatf("rnd%0d", t), w0, enwr, ewb, e);
        end

        check("port_width_and_we_rules", 64'(side_bad), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
